proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Run controller that sequences the single-cycle processor core. It holds the core in reset and releases it on command. It gates every PC update and register-file write through one enable, for free-run or single-step execution. It stops the core on a halt instruction, a PC breakpoint, an external stop or a cycle-budget timeout, and exposes state and an executed-instruction counter to the top level and bench.

## Interface
- `PC_W`, 8, width of core PC / breakpoint address.
- `CYCLE_W`, 16, width of executed-instruction counter.
- `TIMEOUT`, 1000, max instructions executed before forced halt; must fit in `CYCLE_W`.

- `clk_i` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; returns block to IDLE.
- `start_i` in 1: level sampled each cycle; run / resume / restart request.
- `step_i` in 1: execute exactly one instruction.
- `stop_i` in 1: pause a running core.
- `instr_i` in 32: instruction currently fetched by the core (`B,C,WE,WS,ALUop,RA1,RA2,WA,CONST` format).
- `pc_i` in `PC_W`: current core PC.
- `bp_en_i` in 1: breakpoint enable.
- `bp_addr_i` in `PC_W`: breakpoint PC.
- `core_rst_o` out 1: reset to core (PC and regfile).
- `core_en_o` out 1: core commit enable; core updates PC and writes regfile only when 1.
- `state_o` out 2: IDLE=0, RUN=1, PAUSE=2, HALT=3 (STEP reports as RUN).
- `done_o` out 1: one-cycle pulse on entry to HALT.
- `timeout_o` out 1: sticky; HALT was caused by timeout.
- `cycles_o` out `CYCLE_W`: instructions executed (cycles with `core_en_o`=1) since last start from IDLE.

## Operation
- Halt instruction: `instr_i[31]`=1, `instr_i[30]`=0, `instr_i[7:0]`=0 (unconditional jump to self). Detection is combinational.
- Breakpoint hit: `bp_en_i` && `pc_i`==`bp_addr_i` && !`bp_skip`.
- `bp_skip` register:
  - Set on every PAUSE→RUN/STEP transition.
  - Cleared after the first executed instruction.
  - Purpose: resuming at a breakpoint executes that instruction instead of re-trapping.
- IDLE:
  - `core_rst_o`=1, `core_en_o`=0.
  - `start_i` → RUN, clear `cycles_o` and `timeout_o`.
  - Else `step_i` → STEP, same clears.
  - `start_i` wins if both are asserted.
- RUN: checks each cycle in this priority order:
  1. Halt instruction → HALT.
  2. `cycles_o`==`TIMEOUT` → HALT, set `timeout_o`.
  3. Breakpoint hit → PAUSE.
  4. `stop_i` → PAUSE.
  5. Otherwise `core_en_o`=1 and stay in RUN.
- STEP:
  - Halt instruction or timeout → HALT as in RUN.
  - Otherwise `core_en_o`=1 for exactly this cycle, then → PAUSE.
  - Breakpoints are ignored in STEP.
- PAUSE:
  - `core_en_o`=0, core not in reset, architectural state frozen.
  - `step_i` → STEP; else `start_i` → RUN.
  - `stop_i` is ignored.
- HALT:
  - `core_en_o`=0, `core_rst_o`=0; regfile keeps its result for display.
  - `start_i` → IDLE (one reset cycle to the core); a further `start_i` reruns the program.
- `core_en_o` is combinational from the state register, `instr_i`, `pc_i` and `cycles_o`. It is 0 in any cycle where a HALT/PAUSE transition is taken, so the trapping instruction never commits.
- `core_rst_o` = (state==IDLE), decoded from the register.
- `cycles_o` increments by 1 on every edge where `core_en_o`=1.
  - It never wraps, because timeout fires at `TIMEOUT`.
  - It holds in PAUSE and HALT.
- `reset` at any point, including mid-RUN or mid-STEP:
  - Next state is IDLE.
  - All registers clear.
  - No commit occurs on that edge (`core_en_o` is forced to 0 while `reset`=1).

## Timing
- Reset values:
  - State IDLE, `core_rst_o`=1, `core_en_o`=0.
  - `done_o`=0, `timeout_o`=0, `cycles_o`=0, `bp_skip`=0.
- `start_i` sampled at edge k in IDLE:
  - The core is out of reset after edge k.
  - The first instruction (PC 0) commits at edge k+1.
- `stop_i` sampled high in RUN at edge k: the cycle before edge k commits no instruction, and `state_o`=PAUSE after edge k.
- `done_o` is high for exactly the one cycle following the edge that enters HALT.
- STEP commits exactly one instruction (or none if the instruction is a halt) and occupies one cycle.

## Test plan
- Program `0:R1←5, 1:R2←R1+R1, 2:R3←R2-R1, 3:halt`, assert `start_i` → HALT with `cycles_o`=3, `done_o` pulsed once, `pc_i` held at 3, `timeout_o`=0.
- Same program with `bp_en_i`=1, `bp_addr_i`=2, `start_i`:
  - PAUSE with `cycles_o`=2 and R3 unwritten.
  - `start_i` again → HALT with `cycles_o`=3.
- From IDLE, four `step_i` pulses separated by idle cycles:
  - `cycles_o` goes 1, 2, 3.
  - The fourth pulse enters HALT with `cycles_o`=3.
- Infinite loop `0:R1←R1+R3, 1:jump -1` with `TIMEOUT`=20 → HALT, `timeout_o`=1, `cycles_o`=20.
- Assert `stop_i` during RUN, then `start_i` and `step_i` together in PAUSE:
  - STEP wins, one commit, back to PAUSE.
  - `reset` mid-RUN → `state_o`=0, `cycles_o`=0, `core_rst_o`=1 on the next cycle.

Source files
------------

// File: rtl/proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_run_ctrl
// Description : Run controller for the single-cycle processor core. Holds the
//               core in reset, gates every commit through one enable for
//               free-run or single-step execution, and stops the core on a
//               halt instruction, PC breakpoint, external stop or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_run_ctrl #(
    parameter int PC_W    = 8,
    parameter int CYCLE_W = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               start_i,
    input  logic               step_i,
    input  logic               stop_i,
    input  logic [31:0]        instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               bp_en_i,
    input  logic [PC_W-1:0]    bp_addr_i,
    output logic               core_rst_o,
    output logic               core_en_o,
    output logic [1:0]         state_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CYCLE_W-1:0] cycles_o
);

    // STEP is a private encoding; it reports externally as RUN.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_HALT  = 3'd3,
        S_STEP  = 3'd4
    } state_t;

    localparam logic [CYCLE_W-1:0] TIMEOUT_CNT = CYCLE_W'(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic [CYCLE_W-1:0] cycles;
    logic               timeout_flag;
    logic               done;
    logic               bp_skip;

    logic               commit;
    logic               clear_run;
    logic               set_timeout;
    logic               set_skip;

    logic               halt_instr;
    logic               timed_out;
    logic               bp_hit;
    logic               unused_instr_bits;

    // Halt is an unconditional jump-to-self: B=1, C=0, offset 0.
    assign halt_instr = instr_i[31] & ~instr_i[30] & (instr_i[7:0] == 8'd0);
    assign timed_out  = (cycles == TIMEOUT_CNT);
    assign bp_hit     = bp_en_i & (pc_i == bp_addr_i) & ~bp_skip;

    // Remaining instruction fields belong to the core datapath.
    assign unused_instr_bits = ^instr_i[29:8];

    // Next-state and commit decode; a trapping cycle never commits.
    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        clear_run   = 1'b0;
        set_timeout = 1'b0;
        set_skip    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_RUN;
                    clear_run  = 1'b1;
                end else if (step_i) begin
                    state_next = S_STEP;
                    clear_run  = 1'b1;
                end
            end
            S_RUN: begin
                if (halt_instr) begin
                    state_next = S_HALT;
                end else if (timed_out) begin
                    state_next  = S_HALT;
                    set_timeout = 1'b1;
                end else if (bp_hit || stop_i) begin
                    state_next = S_PAUSE;
                end else begin
                    commit = 1'b1;
                end
            end
            S_STEP: begin
                if (halt_instr) begin
                    state_next = S_HALT;
                end else if (timed_out) begin
                    state_next  = S_HALT;
                    set_timeout = 1'b1;
                end else begin
                    commit     = 1'b1;
                    state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (step_i) begin
                    state_next = S_STEP;
                    set_skip   = 1'b1;
                end else if (start_i) begin
                    state_next = S_RUN;
                    set_skip   = 1'b1;
                end
            end
            S_HALT: begin
                if (start_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Executed-instruction counter, timeout flag, done pulse and breakpoint skip.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            cycles       <= '0;
            timeout_flag <= 1'b0;
            done         <= 1'b0;
            bp_skip      <= 1'b0;
        end else begin
            if (clear_run) begin
                cycles <= '0;
            end else if (commit) begin
                cycles <= cycles + 1'b1;
            end

            if (clear_run) begin
                timeout_flag <= 1'b0;
            end else if (set_timeout) begin
                timeout_flag <= 1'b1;
            end

            done <= (state_next == S_HALT) && (state != S_HALT);

            if (set_skip) begin
                bp_skip <= 1'b1;
            end else if (commit) begin
                bp_skip <= 1'b0;
            end
        end
    end

    assign core_en_o  = commit & ~reset;
    assign core_rst_o = (state == S_IDLE);
    assign state_o    = (state == S_STEP) ? 2'd1 : state[1:0];
    assign done_o     = done;
    assign timeout_o  = timeout_flag;
    assign cycles_o   = cycles;

endmodule
`default_nettype wire

// File: tb/tb_proc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_run_ctrl
// Description : Bench for proc_run_ctrl with a tiny core model, a behavioural
//               reference of the run rules, directed scenarios and random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_run_ctrl;

    localparam int PC_W    = 8;
    localparam int CYCLE_W = 16;
    localparam int TO      = 20;

    logic               clk_i = 1'b0;
    logic               reset = 1'b1;
    logic               start_i = 1'b0;
    logic               step_i = 1'b0;
    logic               stop_i = 1'b0;
    logic [31:0]        instr_i;
    logic [PC_W-1:0]    pc_i;
    logic               bp_en_i = 1'b0;
    logic [PC_W-1:0]    bp_addr_i = '0;
    logic               core_rst_o;
    logic               core_en_o;
    logic [1:0]         state_o;
    logic               done_o;
    logic               timeout_o;
    logic [CYCLE_W-1:0] cycles_o;

    proc_run_ctrl #(.PC_W(PC_W), .CYCLE_W(CYCLE_W), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .reset(reset), .start_i(start_i), .step_i(step_i),
        .stop_i(stop_i), .instr_i(instr_i), .pc_i(pc_i), .bp_en_i(bp_en_i),
        .bp_addr_i(bp_addr_i), .core_rst_o(core_rst_o), .core_en_o(core_en_o),
        .state_o(state_o), .done_o(done_o), .timeout_o(timeout_o),
        .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- bench core: program ROM, PC, register file ----------
    logic [31:0] mem [0:15];
    logic [PC_W-1:0] core_pc;
    logic [7:0] regs [0:7];

    function automatic logic [31:0] mk_alu(input int op, input int wa, input int ra1,
                                           input int ra2, input int k);
        logic [31:0] w;
        w = 32'h2000_0000;
        w[28:27] = 2'(op);
        w[26:24] = 3'(ra1);
        w[22:20] = 3'(ra2);
        w[18:16] = 3'(wa);
        w[7:0]   = 8'(k);
        return w;
    endfunction

    function automatic logic [31:0] mk_jmp(input int off);
        logic [31:0] w;
        w = 32'h8000_0000;
        w[7:0] = 8'(off);
        return w;
    endfunction

    assign pc_i    = core_pc;
    assign instr_i = mem[core_pc[3:0]];

    // Core: reset from the controller, otherwise commit only when enabled.
    always @(posedge clk_i) begin
        logic [31:0] w;
        w = mem[core_pc[3:0]];
        if (core_rst_o) begin
            core_pc <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else if (core_en_o) begin
            if (w[31]) begin
                core_pc <= core_pc + w[7:0];
            end else begin
                core_pc <= core_pc + 1'b1;
                case (w[28:27])
                    2'd0:    regs[w[18:16]] <= w[7:0];
                    2'd1:    regs[w[18:16]] <= regs[w[26:24]] + regs[w[22:20]];
                    default: regs[w[18:16]] <= regs[w[26:24]] - regs[w[22:20]];
                endcase
            end
        end
    end

    task automatic load_prog(input int which);
        for (int i = 0; i < 16; i++) mem[i] = mk_jmp(0);
        if (which == 0) begin
            mem[0] = mk_alu(0, 1, 0, 0, 5);
            mem[1] = mk_alu(1, 2, 1, 1, 0);
            mem[2] = mk_alu(2, 3, 2, 1, 0);
            mem[3] = mk_jmp(0);
        end else begin
            mem[0] = mk_alu(1, 1, 1, 3, 0);
            mem[1] = mk_jmp(-1);
        end
    endtask

    // ---------------- behavioural reference of the run rules -------------
    // Modes: 0 idle, 1 run, 2 pause, 3 halt, 4 single step.
    int m_mode = 0, n_mode;
    int m_cyc  = 0, n_cyc;
    bit m_to   = 0, n_to;
    bit m_done = 0, n_done;
    bit m_skip = 0, n_skip;
    bit model_on = 0;
    int done_cnt = 0;

    always @(negedge clk_i) begin
        bit is_halt, at_limit, trap, en;
        int rep;
        is_halt  = instr_i[31] && !instr_i[30] && (instr_i[7:0] == 8'd0);
        at_limit = (m_cyc == TO);
        trap     = bp_en_i && (pc_i == bp_addr_i) && !m_skip;
        en = 0;
        if (m_mode == 1) en = !is_halt && !at_limit && !trap && !stop_i;
        if (m_mode == 4) en = !is_halt && !at_limit;
        if (reset) en = 0;
        rep = (m_mode == 4) ? 1 : m_mode;
        if (model_on) begin
            check("state_o",    state_o,    rep);
            check("core_en_o",  core_en_o,  en);
            check("core_rst_o", core_rst_o, m_mode == 0);
            check("done_o",     done_o,     m_done);
            check("timeout_o",  timeout_o,  m_to);
            check("cycles_o",   cycles_o,   m_cyc);
            if (done_o) done_cnt++;
        end
        n_mode = m_mode; n_cyc = m_cyc; n_to = m_to; n_skip = m_skip;
        if (en) begin
            n_cyc  = m_cyc + 1;
            n_skip = 0;
        end
        if (m_mode == 0 && (start_i || step_i)) begin
            n_mode = start_i ? 1 : 4;
            n_cyc  = 0;
            n_to   = 0;
        end else if ((m_mode == 1 || m_mode == 4) && (is_halt || at_limit)) begin
            n_mode = 3;
            if (!is_halt) n_to = 1;
        end else if (m_mode == 1 && !en) begin
            n_mode = 2;
        end else if (m_mode == 4) begin
            n_mode = 2;
        end else if (m_mode == 2 && (step_i || start_i)) begin
            n_mode = step_i ? 4 : 1;
            n_skip = 1;
        end else if (m_mode == 3 && start_i) begin
            n_mode = 0;
        end
        n_done = (n_mode == 3) && (m_mode != 3);
        if (reset) begin
            n_mode = 0; n_cyc = 0; n_to = 0; n_done = 0; n_skip = 0;
        end
    end

    always @(posedge clk_i) begin
        m_mode = n_mode; m_cyc = n_cyc; m_to = n_to; m_done = n_done; m_skip = n_skip;
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1; tick(1); start_i = 1'b0;
    endtask

    task automatic pulse_step();
        step_i = 1'b1; tick(1); step_i = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        while (state_o != s && n < budget) begin
            tick(1);
            n++;
        end
        check(name, state_o, s);
    endtask

    int c0;

    initial begin
        load_prog(0);
        tick(2);
        model_on = 1;
        reset = 1'b0;
        check("reset_state", state_o, 0);
        check("reset_core_rst", core_rst_o, 1);
        check("reset_cycles", cycles_o, 0);
        check("reset_timeout", timeout_o, 0);

        // Plain run to the halt instruction.
        done_cnt = 0;
        pulse_start();
        wait_state(2'd3, 50, "run_to_halt");
        tick(3);
        check("prog_cycles", cycles_o, 3);
        check("prog_done_cnt", done_cnt, 1);
        check("prog_pc", pc_i, 3);
        check("prog_timeout", timeout_o, 0);
        check("prog_r3", regs[3], 5);

        // Breakpoint at PC 2, then resume past it.
        pulse_start();
        bp_en_i = 1'b1; bp_addr_i = 8'd2;
        pulse_start();
        wait_state(2'd2, 50, "bp_pause");
        check("bp_cycles", cycles_o, 2);
        check("bp_r3_unwritten", regs[3], 0);
        pulse_start();
        wait_state(2'd3, 50, "bp_resume_halt");
        check("bp_resume_cycles", cycles_o, 3);
        bp_en_i = 1'b0;

        // Single stepping from IDLE.
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            pulse_step();
            tick(3);
            check("step_state", state_o, 2);
            check("step_cycles", cycles_o, i);
        end
        pulse_step();
        tick(3);
        check("step4_state", state_o, 3);
        check("step4_cycles", cycles_o, 3);

        // Infinite loop hits the instruction budget.
        pulse_start();
        load_prog(1);
        pulse_start();
        wait_state(2'd3, 100, "timeout_halt");
        tick(1);
        check("timeout_flag", timeout_o, 1);
        check("timeout_cycles", cycles_o, TO);

        // Stop, then step and start together, then reset mid-run.
        pulse_start();
        pulse_start();
        tick(3);
        stop_i = 1'b1; tick(1); stop_i = 1'b0;
        check("stop_state", state_o, 2);
        c0 = int'(cycles_o);
        start_i = 1'b1; step_i = 1'b1; tick(1); start_i = 1'b0; step_i = 1'b0;
        tick(2);
        check("step_wins_state", state_o, 2);
        check("step_wins_cycles", cycles_o, c0 + 1);
        pulse_start();
        tick(3);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("midrun_reset_state", state_o, 0);
        check("midrun_reset_cycles", cycles_o, 0);
        check("midrun_reset_core_rst", core_rst_o, 1);

        // Randomised control traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 63) == 0);
            start_i   = ($urandom_range(0, 7) == 0);
            step_i    = ($urandom_range(0, 7) == 0);
            stop_i    = ($urandom_range(0, 9) == 0);
            bp_en_i   = $urandom_range(0, 1);
            bp_addr_i = 8'($urandom_range(0, 3));
            if (reset) load_prog($urandom_range(0, 1));
            tick(1);
        end
        reset = 1'b0; start_i = 1'b0; step_i = 1'b0; stop_i = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
